// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch (IF) and data memory (DM).
// Optional performance counters are enabled with `define ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [15:0]       conflict_cnt_o
`endif
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [3:0] CntInit = 4'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic              owner_dm_q, owner_dm_d;
  logic              last_dm_q, last_dm_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              grant_dm;

  // DM wins a tie unless it also took the previous grant.
  assign grant_dm = dm_req_i & ~(if_req_i & last_dm_q);

  always_comb begin
    state_d     = state_q;
    owner_dm_d  = owner_dm_q;
    last_dm_d   = last_dm_q;
    cnt_d       = cnt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (if_req_i || dm_req_i) begin
          owner_dm_d  = grant_dm;
          last_dm_d   = grant_dm;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_dm & dm_we_i;
          mem_addr_d  = grant_dm ? dm_addr_i : if_addr_i;
          mem_wdata_d = grant_dm ? dm_wdata_i : '0;
          cnt_d       = CntInit;
          state_d     = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!mem_we_q) begin
            if (owner_dm_q) dm_rdata_d = mem_rdata_i;
            else            if_rdata_d = mem_rdata_i;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_dm_q  <= 1'b0;
      last_dm_q   <= 1'b0;
      cnt_q       <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_dm_q  <= owner_dm_d;
      last_dm_q   <= last_dm_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ready_o  = (state_q == StDone) & ~owner_dm_q;
  assign dm_ready_o  = (state_q == StDone) & owner_dm_q;
  assign stall_o     = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o);

`ifdef ARB_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] conflict_cnt_q;

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      stall_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (stall_o && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((state_q == StIdle) && if_req_i && dm_req_i && (conflict_cnt_q != '1)) begin
        conflict_cnt_q <= conflict_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt_o    = stall_cnt_q;
  assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-schedule reference model.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned L  = 2;

  logic          clk_i = 1'b0;
  logic          reset = 1'b1;
  logic          if_req_i, dm_req_i, dm_we_i;
  logic [AW-1:0] if_addr_i, dm_addr_i, mem_addr_o;
  logic [DW-1:0] dm_wdata_i, if_rdata_o, dm_rdata_o, mem_wdata_o, mem_rdata_i;
  logic          if_ready_o, dm_ready_o, mem_en_o, mem_we_o, stall_o;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   stall_cnt;
  logic [15:0]   conflict_cnt;
`endif

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) dut (
    .clk_i       (clk_i),
    .reset       (reset),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_ready_o  (if_ready_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_rdata_o  (dm_rdata_o),
    .dm_ready_o  (dm_ready_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .stall_o     (stall_o)
`ifdef ARB_PERF_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt),
    .conflict_cnt_o (conflict_cnt)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] pattern(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // Memory model: data is valid only on the L-th consecutive enable cycle.
  int en_run;
  always @(posedge clk_i or posedge reset) begin
    if (reset)         en_run <= 0;
    else if (mem_en_o) en_run <= en_run + 1;
    else               en_run <= 0;
  end
  assign mem_rdata_i = (mem_en_o && en_run == int'(L) - 1) ? pattern(mem_addr_o) : 32'hBAD0_BAD0;

  task automatic nxt;
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp;
    @(negedge clk_i);
  endtask

  task automatic idle_inputs;
    if_req_i = 0; dm_req_i = 0; dm_we_i = 0;
    if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
  endtask

  task automatic apply_reset;
    idle_inputs();
    reset = 1;
    @(posedge clk_i);
    @(negedge clk_i);
    reset = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk_i);
    #1;
    total++;
    if ({mem_en_o, mem_we_o, if_ready_o, dm_ready_o, stall_o} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=00000",
               {mem_en_o, mem_we_o, if_ready_o, dm_ready_o, stall_o});
    end
    total++;
    if ({mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o} !== 128'b0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0", {mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o});
    end
    if_req_i = 1;
    #1;
    total++;
    if (stall_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_stall_eq got=%b want=1", stall_o);
    end
    if_req_i = 0;
`ifdef ARB_PERF_CNT_EN
    total++;
    if ({stall_cnt, conflict_cnt} !== 48'b0) begin
      bad++;
      $display("FAIL reset_perf got=%h want=0", {stall_cnt, conflict_cnt});
    end
`endif
    @(negedge clk_i);
    reset = 0;
  endtask

  task automatic test_if_read;
    nxt(); if_req_i = 1; if_addr_i = 32'h10;
    smp();
    total++;
    if ({mem_en_o, stall_o} !== 2'b01) begin
      bad++; $display("FAIL ifrd_c0 got=%b want=01", {mem_en_o, stall_o});
    end
    nxt(); smp();
    total++;
    if ({mem_en_o, mem_we_o, mem_addr_o} !== {2'b10, 32'h10}) begin
      bad++; $display("FAIL ifrd_c1 got=%h want=%h", {mem_en_o, mem_we_o, mem_addr_o}, {2'b10, 32'h10});
    end
    nxt(); smp();
    total++;
    if (mem_en_o !== 1'b1) begin
      bad++; $display("FAIL ifrd_c2_en got=%b want=1", mem_en_o);
    end
    nxt(); smp();
    total++;
    if ({if_ready_o, dm_ready_o, mem_en_o, stall_o} !== 4'b1000) begin
      bad++; $display("FAIL ifrd_c3 got=%b want=1000", {if_ready_o, dm_ready_o, mem_en_o, stall_o});
    end
    total++;
    if (if_rdata_o !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL ifrd_data got=%h want=deadbeef", if_rdata_o);
    end
    nxt(); if_req_i = 0; smp();
    total++;
    if ({if_ready_o, stall_o} !== 2'b00) begin
      bad++; $display("FAIL ifrd_c4 got=%b want=00", {if_ready_o, stall_o});
    end
  endtask

  task automatic test_dm_write;
    nxt(); dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h100; dm_wdata_i = 32'h1234_5678;
    smp();
    nxt(); smp();
    total++;
    if ({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {2'b11, 32'h100, 32'h1234_5678}) begin
      bad++; $display("FAIL dmwr_c1 got=%h want=%h", {mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o},
                      {2'b11, 32'h100, 32'h1234_5678});
    end
    nxt(); smp();
    total++;
    if ({mem_en_o, mem_we_o} !== 2'b11) begin
      bad++; $display("FAIL dmwr_c2 got=%b want=11", {mem_en_o, mem_we_o});
    end
    nxt(); smp();
    total++;
    if ({dm_ready_o, if_ready_o, mem_en_o, mem_we_o} !== 4'b1000) begin
      bad++; $display("FAIL dmwr_c3 got=%b want=1000", {dm_ready_o, if_ready_o, mem_en_o, mem_we_o});
    end
    total++;
    if (dm_rdata_o !== 32'h0) begin
      bad++; $display("FAIL dmwr_rdata_kept got=%h want=0", dm_rdata_o);
    end
    nxt(); idle_inputs();
  endtask

  task automatic test_reset_mid;
    nxt(); dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h200;
    smp();
    nxt(); smp();
    total++;
    if ({mem_en_o, mem_addr_o} !== {1'b1, 32'h200}) begin
      bad++; $display("FAIL rstmid_c1 got=%h want=%h", {mem_en_o, mem_addr_o}, {1'b1, 32'h200});
    end
    nxt(); #2;
    reset = 1; dm_req_i = 0; if_req_i = 1; if_addr_i = 32'h44;
    #1;
    total++;
    if ({mem_en_o, mem_we_o} !== 2'b00) begin
      bad++; $display("FAIL rstmid_en_drop got=%b want=00", {mem_en_o, mem_we_o});
    end
    nxt();
    total++;
    if ({dm_ready_o, if_ready_o} !== 2'b00) begin
      bad++; $display("FAIL rstmid_no_ready got=%b want=00", {dm_ready_o, if_ready_o});
    end
    @(negedge clk_i);
    reset = 0;
    nxt(); smp();
    total++;
    if ({mem_en_o, mem_addr_o} !== {1'b1, 32'h44}) begin
      bad++; $display("FAIL rstmid_if_grant got=%h want=%h", {mem_en_o, mem_addr_o}, {1'b1, 32'h44});
    end
    nxt(); nxt(); smp();
    total++;
    if ({if_ready_o, dm_ready_o, if_rdata_o} !== {2'b10, pattern(32'h44)}) begin
      bad++; $display("FAIL rstmid_if_done got=%h want=%h", {if_ready_o, dm_ready_o, if_rdata_o},
                      {2'b10, pattern(32'h44)});
    end
    nxt(); idle_inputs();
  endtask

  task automatic test_drop;
    nxt(); if_req_i = 1; if_addr_i = 32'h30;
    smp();
    nxt(); smp();
    nxt(); if_req_i = 0; dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h300;
    smp();
    total++;
    if ({stall_o, mem_en_o, mem_addr_o} !== {2'b11, 32'h30}) begin
      bad++; $display("FAIL drop_c2 got=%h want=%h", {stall_o, mem_en_o, mem_addr_o}, {2'b11, 32'h30});
    end
    nxt(); smp();
    total++;
    if ({if_ready_o, dm_ready_o, if_rdata_o} !== {2'b10, pattern(32'h30)}) begin
      bad++; $display("FAIL drop_if_ready got=%h want=%h", {if_ready_o, dm_ready_o, if_rdata_o},
                      {2'b10, pattern(32'h30)});
    end
    nxt(); smp();
    total++;
    if (mem_en_o !== 1'b0) begin
      bad++; $display("FAIL drop_idle_en got=%b want=0", mem_en_o);
    end
    nxt(); smp();
    total++;
    if ({mem_en_o, mem_addr_o} !== {1'b1, 32'h300}) begin
      bad++; $display("FAIL drop_dm_grant got=%h want=%h", {mem_en_o, mem_addr_o}, {1'b1, 32'h300});
    end
    nxt(); nxt(); smp();
    total++;
    if ({dm_ready_o, dm_rdata_o} !== {1'b1, pattern(32'h300)}) begin
      bad++; $display("FAIL drop_dm_done got=%h want=%h", {dm_ready_o, dm_rdata_o},
                      {1'b1, pattern(32'h300)});
    end
    nxt(); idle_inputs();
  endtask

  task automatic test_back_to_back;
    apply_reset();
    nxt(); if_req_i = 1; if_addr_i = 32'h40; dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h80;
    for (int j = 0; j < 4; j++) begin
      nxt(); smp();
      total++;
      if (mem_addr_o !== ((j % 2 == 0) ? 32'h80 : 32'h40)) begin
        bad++; $display("FAIL b2b_grant%0d got=%h want=%h", j, mem_addr_o,
                        (j % 2 == 0) ? 32'h80 : 32'h40);
      end
      nxt(); nxt(); smp();
      total++;
      if ({if_ready_o, dm_ready_o} !== ((j % 2 == 0) ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL b2b_ready%0d got=%b want=%b", j, {if_ready_o, dm_ready_o},
                        (j % 2 == 0) ? 2'b01 : 2'b10);
      end
      nxt();
    end
`ifdef ARB_PERF_CNT_EN
    smp();
    total++;
    if ({stall_cnt, conflict_cnt} !== {32'd16, 16'd4}) begin
      bad++; $display("FAIL b2b_perf got=%0d/%0d want=16/4", stall_cnt, conflict_cnt);
    end
`endif
    idle_inputs();
  endtask

  task automatic test_random;
    bit          rq[2], we[2], hold[2], done_prev[2], e_rdy[2];
    logic [31:0] ad[2], wd[2], exp_rd[2];
    bit          busy, was_busy, last_dm, cur_we, e_en, e_stall;
    int          own, tg, k;
    logic [31:0] cur_addr, cur_wdata;
    int unsigned stall_m, conf_m;
    apply_reset();
    busy = 0; last_dm = 0; own = 0; tg = 0; cur_we = 0; cur_addr = '0; cur_wdata = '0;
    stall_m = 0; conf_m = 0;
    for (int r = 0; r < 2; r++) begin
      rq[r] = 0; we[r] = 0; hold[r] = 0; done_prev[r] = 0; ad[r] = '0; wd[r] = '0; exp_rd[r] = '0;
    end
    nxt();
    for (int cyc = 0; cyc < 600; cyc++) begin
      k = cyc - tg;
      for (int r = 0; r < 2; r++) begin
        if (done_prev[r]) begin rq[r] = 0; hold[r] = 0; end
        if (!rq[r] && !hold[r] && $urandom_range(1) == 1) begin
          rq[r] = 1;
          ad[r] = $urandom & 32'hFFFF_FFFC;
          we[r] = (r == 1) ? 1'($urandom_range(1)) : 1'b0;
          wd[r] = $urandom;
        end else if (rq[r] && busy && own == r && k >= 1 && k <= int'(L) &&
                     $urandom_range(7) == 0) begin
          rq[r] = 0; hold[r] = 1;
        end
      end
      if_req_i = rq[0]; if_addr_i = ad[0];
      dm_req_i = rq[1]; dm_we_i = we[1]; dm_addr_i = ad[1]; dm_wdata_i = wd[1];
      smp();
      e_en = busy && k >= 1 && k <= int'(L);
      for (int r = 0; r < 2; r++) e_rdy[r] = busy && k == int'(L) + 1 && own == r;
      if (busy && k == int'(L) + 1 && !cur_we) exp_rd[own] = pattern(cur_addr);
      e_stall = (rq[0] && !e_rdy[0]) || (rq[1] && !e_rdy[1]);
      total++;
      if ({if_ready_o, dm_ready_o} !== {e_rdy[0], e_rdy[1]}) begin
        bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, {if_ready_o, dm_ready_o},
                        {e_rdy[0], e_rdy[1]});
      end
      total++;
      if ({mem_en_o, mem_we_o} !== {e_en, e_en & cur_we}) begin
        bad++; $display("FAIL rnd_en_we cyc=%0d got=%b want=%b", cyc, {mem_en_o, mem_we_o},
                        {e_en, e_en & cur_we});
      end
      if (e_en) begin
        total++;
        if (mem_addr_o !== cur_addr || (cur_we && mem_wdata_o !== cur_wdata)) begin
          bad++; $display("FAIL rnd_mem_bus cyc=%0d got=%h/%h want=%h/%h", cyc, mem_addr_o,
                          mem_wdata_o, cur_addr, cur_wdata);
        end
      end
      total++;
      if ({if_rdata_o, dm_rdata_o} !== {exp_rd[0], exp_rd[1]}) begin
        bad++; $display("FAIL rnd_rdata cyc=%0d got=%h/%h want=%h/%h", cyc, if_rdata_o, dm_rdata_o,
                        exp_rd[0], exp_rd[1]);
      end
      total++;
      if (stall_o !== e_stall) begin
        bad++; $display("FAIL rnd_stall cyc=%0d got=%b want=%b", cyc, stall_o, e_stall);
      end
      was_busy = busy;
      if (busy && k == int'(L) + 1) busy = 0;
      if (!was_busy && rq[0] && rq[1]) conf_m++;
      if (e_stall) stall_m++;
      if (!was_busy && (rq[0] || rq[1])) begin
        own = (rq[0] && rq[1]) ? (last_dm ? 0 : 1) : (rq[1] ? 1 : 0);
        last_dm = (own == 1);
        tg = cyc; busy = 1;
        cur_we = we[own]; cur_addr = ad[own]; cur_wdata = wd[own];
      end
      for (int r = 0; r < 2; r++) done_prev[r] = e_rdy[r];
      nxt();
    end
`ifdef ARB_PERF_CNT_EN
    total++;
    if (stall_cnt !== stall_m || conflict_cnt !== 16'(conf_m)) begin
      bad++; $display("FAIL rnd_perf got=%0d/%0d want=%0d/%0d", stall_cnt, conflict_cnt,
                      stall_m, conf_m);
    end
`endif
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_if_read();
    test_dm_write();
    test_reset_mid();
    test_drop();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between instruction fetch (IF requester) and the data-memory stage (DM requester) of the 5-stage pipelined CPU.
- Sequences each fixed-latency access with a small FSM and returns read data with a one-cycle ready pulse.
- Drives stall_o so the hazard logic can freeze the PC and the pipeline registers while an access is outstanding.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width
- MEM_LAT, 2, cycles the memory needs from enable to valid read data; legal range 1..15

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch request; held high until if_ready_o is seen
- if_addr_i  in  ADDR_W  fetch address; stable while if_req_i is high
- if_rdata_o  out  DATA_W  fetched instruction; valid when if_ready_o is high
- if_ready_o  out  1  one-cycle completion pulse for IF
- dm_req_i  in  1  data request; held high until dm_ready_o is seen
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_rdata_o  out  DATA_W  load data; valid when dm_ready_o is high
- dm_ready_o  out  1  one-cycle completion pulse for DM
- mem_en_o  out  1  memory enable
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data; valid on the MEM_LAT-th cycle of mem_en_o
- stall_o  out  1  combinational: (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o)

Behaviour:
- Reset values: all outputs 0 except stall_o, which follows its equation. Internal state: IDLE, cnt = 0, last_grant = IF.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, arbitration:
  - Only one requester: grant it.
  - Both requesting: DM wins unless last_grant == DM, in which case IF wins. This alternates grants and prevents starvation.
- Grant edge: register owner, address, write data and we into the mem_* outputs; mem_en_o = 1; cnt = MEM_LAT-1; last_grant = owner; go to BUSY.
- BUSY: mem_* outputs held constant.
  - cnt != 0: decrement cnt.
  - cnt == 0: capture mem_rdata_i into the owner's rdata register (reads only; the rdata register is unchanged on writes); mem_en_o = 0 and mem_we_o = 0; go to DONE.
- DONE: lasts exactly one cycle. The owner's ready_o = 1. No grant is made in this cycle. Next state is IDLE.
- Latency: request seen in cycle 0 → mem_en_o high in cycles 1..MEM_LAT → ready in cycle MEM_LAT+1. Peak throughput is one access per MEM_LAT+2 cycles.
- Request dropped during BUSY: the access completes and ready still pulses. A dropped write is still performed.
- The other requester's request arriving during BUSY or DONE waits; it is arbitrated in the next IDLE cycle.
- *_rdata_o keep their last captured value until the next read by the same owner.
- Reset asserted mid-access: immediate return to IDLE, mem_en_o and mem_we_o forced to 0, no ready pulse, last_grant = IF. A partial write is the memory model's concern.
- Addresses and data are passed through unmodified; no alignment checks.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - Adds output port stall_cnt_o, 32 bits, and output port conflict_cnt_o, 16 bits.
  - stall_cnt_o increments every cycle stall_o == 1.
  - conflict_cnt_o increments every IDLE cycle in which both requests are high.
  - Both counters saturate at all-ones, not wrap, and reset to 0.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- MEM_LAT=2; IF read at 0x0000_0010, memory returns 0xDEAD_BEEF → mem_en_o high in cycles 1-2, mem_addr_o = 0x10, if_ready_o pulses in cycle 3 with if_rdata_o = 0xDEAD_BEEF, stall_o low in cycle 4.
- DM write of 0x1234_5678 to 0x100 → mem_we_o = 1 in cycles 1-2, mem_wdata_o = 0x1234_5678, dm_ready_o pulses in cycle 3, dm_rdata_o unchanged.
- Both requesters held high continuously after reset → grant order DM, IF, DM, IF. Ready pulses every 4 cycles, alternating between the requesters.
- Reset asserted in cycle 2 of a DM read → mem_en_o = 0 immediately, no dm_ready_o pulse. After release, a pending IF request is granted first, since last_grant = IF and only IF is requesting.
- IF drops if_req_i in the second BUSY cycle → if_ready_o still pulses. A DM request raised the same cycle is granted in the IDLE after DONE.
- With ARB_PERF_CNT_EN: preload stall_cnt_o near saturation via a long stall → holds at 0xFFFF_FFFF. With the macro undefined, the build has no stall_cnt_o port.
